i2c_burst_master: RTL and testbench

Parametrised single-master I2C engine that runs complete register transactions (start, slave address, sub-address, N-byte write or repeated-start N-byte read, stop) from a single start pulse. Successor to the fixed single-byte interface driven by the PC control path; adds configurable bus rate, multi-byte bursts with byte-stream handshakes, sub-address auto-increment, and NACK abort with an error flag. Sits between the host register block and the sensor pins (SCL push output, SDA open-drain).

---
 rtl/i2c_burst_master.sv | 163 ++++++++++++++++
 tb/tb_i2c_burst_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_burst_master.sv
// Single-master I2C engine: one start pulse runs start, address, sub-address,
// N-byte write or repeated-start N-byte read, then stop. SDA is open-drain via SDA_oe.
module i2c_burst_master #(
    parameter int CLK_DIV   = 250,
    parameter int MAX_BYTES = 16,
    parameter int CNT_W     = $clog2(MAX_BYTES + 1),
    parameter bit AUTO_INC  = 1'b1
) (
    input  logic             sys_clk,
    input  logic             sys_rstn,
    input  logic             PCControl,
    input  logic [6:0]       SlaveAddress,
    input  logic [6:0]       SubAddress,
    input  logic             ReadWrite,
    input  logic [CNT_W-1:0] ByteCount,
    input  logic [7:0]       WrData,
    output logic             WrReady,
    output logic [7:0]       RdData,
    output logic             RdValid,
    output logic             Busy,
    output logic             Done,
    output logic             Error,
    output logic             SCL,
    output logic             SDA_oe,
    input  logic             SDA_i,
    output logic [7:0]       State
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_ACK_A, S_SUB, S_ACK_S, S_WDATA, S_ACK_W,
        S_RSTART, S_ADDR_R, S_ACK_R, S_RDATA, S_MACK, S_STOP, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             pc_q;
    logic [9:0]       div_q;
    logic [1:0]       qtr_q;
    logic [2:0]       bit_q;
    logic [7:0]       tx_q, rx_q, rd_data_q;
    logic             rd_valid_q, err_q, nack_q;
    logic [CNT_W-1:0] rem_q, n_clamp;
    logic [6:0]       sa_q, sub_q;
    logic             rw_q, ai_q;
    logic             scl_d, oe_d;

    logic active, tick, bit_end, byte_end, sample, in_byte, is_ack, start_acc;

    assign active    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign tick      = (div_q == 10'(CLK_DIV - 1));
    assign bit_end   = tick && (qtr_q == 2'd3);
    assign byte_end  = bit_end && (bit_q == 3'd7);
    assign sample    = (qtr_q == 2'd3) && (div_q == 10'd0);
    assign in_byte   = state_q inside {S_ADDR_W, S_SUB, S_WDATA, S_ADDR_R, S_RDATA};
    assign is_ack    = state_q inside {S_ACK_A, S_ACK_S, S_ACK_W, S_ACK_R};
    assign start_acc = (state_q == S_IDLE) && PCControl && !pc_q;

    always_comb begin
        n_clamp = ByteCount;
        if (ByteCount > CNT_W'(MAX_BYTES)) n_clamp = CNT_W'(MAX_BYTES);
        if (ReadWrite && (n_clamp == '0))  n_clamp = CNT_W'(1);
    end

    assign WrReady = (state_q == S_WDATA) && (bit_q == 3'd0) && (qtr_q == 2'd0) && (div_q == 10'd0);
    assign Busy    = active;
    assign Done    = (state_q == S_DONE);
    assign Error   = err_q;
    assign RdData  = rd_data_q;
    assign RdValid = rd_valid_q;
    assign SCL     = scl_d;
    assign SDA_oe  = oe_d;
    assign State   = {4'd0, state_q};

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        scl_d   = 1'b1;
        oe_d    = 1'b0;
        case (state_q)
            S_IDLE:   if (start_acc) state_d = S_START;
            S_START:  if (bit_end) state_d = S_ADDR_W;
            S_ADDR_W: if (byte_end) state_d = S_ACK_A;
            S_ACK_A:  if (bit_end) state_d = nack_q ? S_STOP : S_SUB;
            S_SUB:    if (byte_end) state_d = S_ACK_S;
            S_ACK_S:  if (bit_end) begin
                          if (nack_q)             state_d = S_STOP;
                          else if (rw_q)          state_d = S_RSTART;
                          else if (rem_q == '0)   state_d = S_STOP;
                          else                    state_d = S_WDATA;
                      end
            S_WDATA:  if (byte_end) state_d = S_ACK_W;
            S_ACK_W:  if (bit_end) state_d = (nack_q || rem_q == CNT_W'(1)) ? S_STOP : S_WDATA;
            S_RSTART: if (bit_end) state_d = S_ADDR_R;
            S_ADDR_R: if (byte_end) state_d = S_ACK_R;
            S_ACK_R:  if (bit_end) state_d = nack_q ? S_STOP : S_RDATA;
            S_RDATA:  if (byte_end) state_d = S_MACK;
            S_MACK:   if (bit_end) state_d = (rem_q == CNT_W'(1)) ? S_STOP : S_RDATA;
            S_STOP:   if (bit_end) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        case (state_q)
            S_START: oe_d = qtr_q[1];
            // SCL dips low in q0 so releasing SDA after the ACK slot is not seen as a stop
            S_RSTART: begin scl_d = (qtr_q != 2'd0); oe_d = qtr_q[1]; end
            S_STOP:   begin scl_d = (qtr_q != 2'd0); oe_d = (qtr_q != 2'd3); end
            S_ADDR_W, S_SUB, S_ADDR_R: begin scl_d = qtr_q[1]; oe_d = ~tx_q[7]; end
            S_WDATA: begin scl_d = qtr_q[1]; oe_d = WrReady ? ~WrData[7] : ~tx_q[7]; end
            S_MACK:  begin scl_d = qtr_q[1]; oe_d = (rem_q != CNT_W'(1)); end
            S_ACK_A, S_ACK_S, S_ACK_W, S_ACK_R, S_RDATA: scl_d = qtr_q[1];
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            pc_q <= 1'b0; div_q <= '0; qtr_q <= '0; bit_q <= '0;
            tx_q <= '0; rx_q <= '0; rd_data_q <= '0; rd_valid_q <= 1'b0;
            err_q <= 1'b0; nack_q <= 1'b0; rem_q <= '0;
            sa_q <= '0; sub_q <= '0; rw_q <= 1'b0; ai_q <= 1'b0;
        end else begin
            pc_q       <= PCControl;
            rd_valid_q <= 1'b0;
            if (!active) begin
                div_q <= '0; qtr_q <= '0; bit_q <= '0;
            end else begin
                div_q <= tick ? 10'd0 : div_q + 10'd1;
                if (tick)    qtr_q <= qtr_q + 2'd1;
                if (bit_end) bit_q <= in_byte ? bit_q + 3'd1 : 3'd0;
            end
            if (start_acc) begin
                sa_q  <= SlaveAddress;
                sub_q <= SubAddress;
                rw_q  <= ReadWrite;
                rem_q <= n_clamp;
                ai_q  <= AUTO_INC && (n_clamp > CNT_W'(1));
                err_q <= 1'b0;
            end
            if (sample) nack_q <= SDA_i;
            if (bit_end && is_ack && nack_q) err_q <= 1'b1;
            if (bit_end && (state_q == S_ACK_W || state_q == S_MACK)) rem_q <= rem_q - CNT_W'(1);

            if (state_d != state_q && state_d == S_ADDR_W)      tx_q <= {sa_q, 1'b0};
            else if (state_d != state_q && state_d == S_SUB)    tx_q <= {ai_q, sub_q};
            else if (state_d != state_q && state_d == S_ADDR_R) tx_q <= {sa_q, 1'b1};
            else if (WrReady)                                   tx_q <= WrData;
            else if (bit_end && in_byte)                        tx_q <= {tx_q[6:0], 1'b0};

            if (sample && state_q == S_RDATA) begin
                rx_q <= {rx_q[6:0], SDA_i};
                if (bit_q == 3'd7) begin
                    rd_data_q  <= {rx_q[6:0], SDA_i};
                    rd_valid_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_burst_master.sv
// Bench for i2c_burst_master: bus-level responder model plus scoreboard of
// expected bus events (start/stop/bytes/master acks) and read data.
module tb_i2c_burst_master;
    localparam int CLK_DIV   = 4;
    localparam int MAX_BYTES = 16;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);
    localparam int T         = 4 * CLK_DIV;
    localparam int EV_S = 256, EV_P = 257, EV_ACK = 258, EV_NACK = 259;

    logic             sys_clk, sys_rstn, PCControl, ReadWrite;
    logic [6:0]       SlaveAddress, SubAddress;
    logic [CNT_W-1:0] ByteCount;
    logic [7:0]       WrData = 8'h00;
    logic             WrReady, RdValid, Busy, Done, Error, SCL, SDA_oe, SDA_i;
    logic [7:0]       RdData, State;
    logic             slv_drv = 1'b0;
    logic             sda_line;

    assign sda_line = ~(SDA_oe | slv_drv);
    assign SDA_i    = sda_line;

    i2c_burst_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W), .AUTO_INC(1'b1)) dut (
        .sys_clk(sys_clk), .sys_rstn(sys_rstn), .PCControl(PCControl),
        .SlaveAddress(SlaveAddress), .SubAddress(SubAddress), .ReadWrite(ReadWrite),
        .ByteCount(ByteCount), .WrData(WrData), .WrReady(WrReady), .RdData(RdData),
        .RdValid(RdValid), .Busy(Busy), .Done(Done), .Error(Error), .SCL(SCL),
        .SDA_oe(SDA_oe), .SDA_i(SDA_i), .State(State)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0, errors = 0;
    int exp_ev[$], obs_ev[$], exp_rd[$], obs_rd[$], slv_tx[$];
    logic [7:0] wr_src[$];
    int n_wrr = 0, n_rdv = 0, n_done = 0;
    bit mon_en = 0, slv_ack = 1;

    // responder state
    logic pscl, psda, cs, cd, mack;
    int   bitn, fbyte;
    bit   in_ack, xmit, rd_pend;
    logic [7:0] rx, txb;

    always @(negedge sys_clk) begin
        if (!mon_en) begin
            pscl = 1'b1; psda = 1'b1; bitn = 0; fbyte = 0; in_ack = 0; xmit = 0;
            rd_pend = 0; slv_drv = 1'b0; mack = 1'b1; rx = '0; txb = '0;
        end else begin
            cs = SCL; cd = sda_line;
            if (WrReady) begin
                n_wrr++;
                WrData = (wr_src.size() > 0) ? wr_src.pop_front() : 8'h00;
            end
            if (RdValid) begin n_rdv++; obs_rd.push_back(int'(RdData)); end
            if (Done) n_done++;
            if (pscl && cs && psda && !cd) begin
                obs_ev.push_back(EV_S);
                bitn = 0; fbyte = 0; in_ack = 0; xmit = 0; rd_pend = 0; slv_drv = 1'b0;
            end else if (pscl && cs && !psda && cd) begin
                obs_ev.push_back(EV_P);
            end else if (!pscl && cs) begin
                if (in_ack) begin
                    if (xmit) begin mack = cd; obs_ev.push_back(cd ? EV_NACK : EV_ACK); end
                end else if (bitn < 8) begin
                    rx = {rx[6:0], cd}; bitn++;
                end
            end else if (pscl && !cs) begin
                if (in_ack) begin
                    in_ack = 0; bitn = 0; slv_drv = 1'b0;
                    if (rd_pend || (xmit && !mack)) begin
                        rd_pend = 0; xmit = 1;
                        txb = (slv_tx.size() > 0) ? 8'(slv_tx.pop_front()) : 8'hFF;
                        slv_drv = ~txb[7];
                    end else xmit = 0;
                end else if (bitn == 8) begin
                    in_ack = 1;
                    if (xmit) slv_drv = 1'b0;
                    else begin
                        obs_ev.push_back(int'(rx));
                        if (slv_ack) slv_drv = 1'b1;
                        if (fbyte == 0 && rx[0] && slv_ack) rd_pend = 1;
                        fbyte++;
                    end
                end else if (xmit && bitn > 0) slv_drv = ~txb[7-bitn];
            end
            pscl = cs; psda = cd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drain(input string tag);
        while (exp_ev.size() > 0 || obs_ev.size() > 0) begin
            if (obs_ev.size() == 0)      chk({tag, "_missing"}, 32'hFFFF_FFFF, exp_ev.pop_front());
            else if (exp_ev.size() == 0) chk({tag, "_extra"}, obs_ev.pop_front(), 32'hFFFF_FFFF);
            else                         chk(tag, obs_ev.pop_front(), exp_ev.pop_front());
        end
        while (exp_rd.size() > 0 || obs_rd.size() > 0) begin
            if (obs_rd.size() == 0)      chk({tag, "_rd_missing"}, 32'hFFFF_FFFF, exp_rd.pop_front());
            else if (exp_rd.size() == 0) chk({tag, "_rd_extra"}, obs_rd.pop_front(), 32'hFFFF_FFFF);
            else                         chk({tag, "_rd"}, obs_rd.pop_front(), exp_rd.pop_front());
        end
    endtask

    task automatic setup(input logic [6:0] sa, input logic [6:0] sub, input logic rw, input int n);
        SlaveAddress = sa; SubAddress = sub; ReadWrite = rw; ByteCount = CNT_W'(n);
    endtask

    task automatic run(input int mid, output int bcyc, output logic d_end, output logic e_end,
                       output logic e_start);
        @(negedge sys_clk) PCControl = 1'b1;
        @(negedge sys_clk) PCControl = 1'b0;
        e_start = Error;
        bcyc = 0;
        while (Busy === 1'b1 && bcyc < 20000) begin
            bcyc++;
            @(negedge sys_clk);
            PCControl = (mid != 0 && bcyc == mid);
        end
        d_end = Done; e_end = Error;
        repeat (8) @(negedge sys_clk);
    endtask

    int bc, w0, r0, d0, k;
    logic de, ee, es;

    initial begin
        sys_rstn = 1'b0; PCControl = 1'b0;
        setup(7'h00, 7'h00, 1'b0, 0);
        repeat (3) @(negedge sys_clk);
        chk("rst_scl", SCL, 1); chk("rst_sda_oe", SDA_oe, 0); chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0); chk("rst_error", Error, 0); chk("rst_wrready", WrReady, 0);
        chk("rst_rdvalid", RdValid, 0); chk("rst_rddata", RdData, 0); chk("rst_state", State, 0);
        @(negedge sys_clk) sys_rstn = 1'b1;
        mon_en = 1;
        repeat (2) @(negedge sys_clk);

        // single-byte write
        setup(7'h19, 7'h20, 1'b0, 1);
        wr_src = '{8'hAA};
        exp_ev = '{EV_S, 'h32, 'h20, 'hAA, EV_P};
        w0 = n_wrr; d0 = n_done;
        run(0, bc, de, ee, es);
        chk("w1_busy", bc, 29 * T); chk("w1_done", de, 1); chk("w1_err", ee, 0);
        chk("w1_wrready", n_wrr - w0, 1); chk("w1_ndone", n_done - d0, 1);
        drain("w1_bus");

        // two-byte read with repeated start
        setup(7'h1E, 7'h03, 1'b1, 2);
        slv_tx = '{'h12, 'h34};
        exp_rd = '{'h12, 'h34};
        exp_ev = '{EV_S, 'h3C, 'h83, EV_S, 'h3D, EV_ACK, EV_NACK, EV_P};
        r0 = n_rdv;
        run(0, bc, de, ee, es);
        chk("r2_done", de, 1); chk("r2_err", ee, 0); chk("r2_rdvalid", n_rdv - r0, 2);
        chk("r2_rddata", RdData, 'h34);
        drain("r2_bus");

        // address NACK
        slv_ack = 0;
        setup(7'h19, 7'h20, 1'b0, 2);
        wr_src = '{8'h11, 8'h22};
        exp_ev = '{EV_S, 'h32, EV_P};
        w0 = n_wrr; d0 = n_done;
        run(0, bc, de, ee, es);
        chk("nack_busy", bc, 11 * T); chk("nack_done", de, 1); chk("nack_err", ee, 1);
        chk("nack_wrready", n_wrr - w0, 0); chk("nack_ndone", n_done - d0, 1);
        chk("nack_err_held", Error, 1);
        drain("nack_bus");
        wr_src.delete();
        slv_ack = 1;

        // clamped burst with a stray start pulse mid-transfer; start clears Error
        setup(7'h19, 7'h10, 1'b0, MAX_BYTES + 5);
        exp_ev = '{EV_S, 'h32, 'h90};
        for (int i = 0; i < MAX_BYTES; i++) begin
            wr_src.push_back(8'(i * 13 + 5));
            exp_ev.push_back((i * 13 + 5) & 'hFF);
        end
        exp_ev.push_back(EV_P);
        w0 = n_wrr; d0 = n_done;
        run(300, bc, de, ee, es);
        chk("clamp_err_cleared", es, 0);
        chk("clamp_busy", bc, (20 + 9 * MAX_BYTES) * T);
        chk("clamp_wrready", n_wrr - w0, MAX_BYTES); chk("clamp_ndone", n_done - d0, 1);
        chk("clamp_err", ee, 0);
        repeat (50) @(negedge sys_clk);
        chk("clamp_idle_busy", Busy, 0); chk("clamp_idle_state", State, 0);
        drain("clamp_bus");

        // reset during WDATA
        setup(7'h19, 7'h20, 1'b0, 2);
        wr_src = '{8'h5A, 8'hC3};
        exp_ev = '{EV_S, 'h32, 'hA0};
        @(negedge sys_clk) PCControl = 1'b1;
        @(negedge sys_clk) PCControl = 1'b0;
        k = 0;
        while (State !== 8'd6 && k < 3000) begin k++; @(negedge sys_clk); end
        chk("rst_mid_reached_wdata", State, 6);
        repeat (T) @(negedge sys_clk);
        mon_en = 0;
        sys_rstn = 1'b0;
        #2;
        chk("rst_mid_scl", SCL, 1); chk("rst_mid_sda_oe", SDA_oe, 0);
        chk("rst_mid_busy", Busy, 0); chk("rst_mid_state", State, 0);
        drain("rst_mid_bus");
        wr_src.delete();
        @(negedge sys_clk) sys_rstn = 1'b1;
        @(negedge sys_clk) mon_en = 1;
        repeat (2) @(negedge sys_clk);

        // pointer-set write (N=0) after reset
        setup(7'h19, 7'h05, 1'b0, 0);
        exp_ev = '{EV_S, 'h32, 'h05, EV_P};
        w0 = n_wrr; d0 = n_done;
        run(0, bc, de, ee, es);
        chk("n0_busy", bc, 20 * T); chk("n0_done", de, 1); chk("n0_err", ee, 0);
        chk("n0_wrready", n_wrr - w0, 0); chk("n0_ndone", n_done - d0, 1);
        drain("n0_bus");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
